joypad_io: RTL and testbench
============================

# joypad_io

CPU-bus responder for the controller ports at $4016/$4017. It owns the strobe written through $4016 and returns one button bit per read of $4016 (pad 1) or $4017 (pad 2). It also polls two NES-style 4021 serial controllers autonomously through a latch/clock/data interface. It sits beside the PPU and APU register responders on the CPU data-bus read mux.

## Interface
- CLK_DIV, 6: clk cycles per half-period of pad_clk and per pad_latch pulse; legal range 1..255.
- POLL_PERIOD, 357955: clk cycles between capture starts; must exceed 16*CLK_DIV+4.
- clk  in  1  system clock. One clock domain.
- rst  in  1  reset, synchronous, active-high.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  one-cycle write strobe.
- cpu_re  in  1  one-cycle read strobe.
- cpu_rdata  out  8  read data. Valid while cpu_rvalid is high; 8'h00 otherwise.
- cpu_rvalid  out  1  high for one cycle, one cycle after a read hit.
- pad_latch  out  1  parallel-load pulse to both controllers.
- pad_clk  out  1  shift clock to both controllers.
- pad1_data, pad2_data  in  1 each  serial data, active-low (0 = pressed); already synchronised upstream.

## Operation
- **Write hit:** cpu_we && cpu_addr==$4016 sets strobe <= cpu_wdata[0]. Writes to $4017 are ignored; that register belongs to the APU frame counter.
- **Read hit:** cpu_re && cpu_addr∈{$4016,$4017}.
  - Response: cpu_rdata = {JOY_OPEN_BUS[7:1], bit} = 8'h40|bit.
  - bit = sr1[0] for $4016, sr2[0] for $4017.
- **Read side effects, strobe=0:** the read sr shifts right with 1 inserted at bit 7. After 8 reads, every further read returns 8'h41.
- **Read side effects, strobe=1:** no shift.
- **Shift-register reload:** every cycle strobe==1, sr1<=snap1 and sr2<=snap2. A read during strobe=1 therefore returns button A of the current snapshot.
- **Simultaneous we and re:** illegal on this bus. The block performs the write only; no rvalid is produced.
- **Bit order in snap and sr (bit 0 first):** A, B, Select, Start, Up, Down, Left, Right. Buttons are stored active-high (button = ~padN_data).

Capture FSM (sub-module):
- **IDLE:** wait for the poll tick.
- **LATCH:** pad_latch=1 for CLK_DIV cycles.
- **GAP:** pad_latch=0 for CLK_DIV cycles. Sample bit 0 of both pads on the last cycle.
- **CLKH:** pad_clk=1 for CLK_DIV cycles.
- **CLKL:** pad_clk=0 for CLK_DIV cycles. Sample bit i (i=1..7) of both pads on the last cycle. After bit 7 go to DONE; otherwise return to CLKH.
- **DONE:** one cycle. Commit both captured bytes to snap1/snap2 together (atomic), then go to IDLE.
- Bits are captured into a temporary register; snap changes only in DONE. CPU reads never observe a partial capture.
- **Poll tick:** a free-running counter issues a tick every POLL_PERIOD cycles. A tick arriving while the FSM is not in IDLE is held pending and starts a capture on the next IDLE cycle. Ticks never queue beyond one.

## Timing
- **Reset values:** cpu_rdata=0, cpu_rvalid=0, pad_latch=0, pad_clk=0, strobe=0, sr1=sr2=0, snap1=snap2=0, FSM=IDLE.
- **First capture:** the poll counter resets to POLL_PERIOD-1, so the first capture starts 1 cycle after rst falls (LATCH in cycle 1).
- **Read latency:** 1 cycle, with registered cpu_rdata and cpu_rvalid.
- **Shift timing:** the shift happens on the same edge that registers the read data, so back-to-back reads on consecutive cycles return consecutive bits.
- **Strobe timing:** a strobe write is effective the next cycle. The first reload happens on the cycle after the write 1; a write 0 freezes sr from the following cycle.
- **DONE and strobe=1 in the same cycle:** the reload that cycle uses the old snap; the new snap is visible one cycle later.
- **Capture length:** 16*CLK_DIV+1 cycles from LATCH entry to DONE inclusive.
- **Reset mid-capture:** immediate return to IDLE with pad_latch=0 and pad_clk=0. snap is cleared and the partial capture is discarded.

## Structure
- **mem_pkg additions:**
  - JOY_OPEN_BUS = 8'h40.
  - JOY_BTN_A..JOY_BTN_RIGHT bit-index constants (0..7).
  - the capture-state enum typedef.
- **Shared with mem_pkg:** ADDR_JOYPAD1 and ADDR_JOYPAD2 are the existing mem_pkg constants, not redefined here.
- **Sub-module joypad_serial_capture:**
  - Contains the FSM, divider, bit counter, poll counter and snap registers.
  - Outputs snap1, snap2 and pad_latch/pad_clk.
- **joypad_io top:** holds the bus decode, strobe, sr1/sr2 and the read path.

## Test plan
- **Reset and first capture:** release rst with pad1 driving A and Start pressed (serial 0,1,1,0,1,1,1,1) -> after DONE, snap1=8'h09; pad_latch is high for exactly CLK_DIV cycles starting 1 cycle after reset.
- **Full read sequence:** write $4016=1, then $4016=0, then 10 reads of $4016 -> rdata 41,40,40,41,40,40,40,40,41,41, with rvalid one cycle after each re.
- **Pad 2 independence:** pad2 has Right only pressed, pad1 none. Strobe 1→0, 8 reads of $4017 -> 40×7 then 41; a following $4016 read returns 40.
- **Strobe held high:** strobe=1 with A pressed, 5 reads -> all 41, with no shift. Then release A and let a capture complete -> the next read returns 40.
- **Capture mid-read:** strobe=0, 3 reads done, then a capture commits a new snap -> reads 4..8 continue the old frozen byte.
- **Reset mid-capture:** rst asserted during CLKH of bit 4 -> next cycle pad_clk=0, snap=0, and a $4016 read after strobe 1→0 returns 40.

Source files
------------

// File: rtl/mem_pkg.sv
// Memory-map constants and shared types for the CPU-bus register responders.
// Holds the joypad port addresses, the open-bus pattern returned in the
// upper bits of a joypad read, button bit positions and the capture FSM states.
package mem_pkg;

  localparam logic [15:0] ADDR_JOYPAD1 = 16'h4016;
  localparam logic [15:0] ADDR_JOYPAD2 = 16'h4017;

  localparam logic [7:0] JOY_OPEN_BUS = 8'h40;

  // Bit positions in snap/sr bytes; bit 0 is shifted out first.
  localparam int JOY_BTN_A      = 0;
  localparam int JOY_BTN_B      = 1;
  localparam int JOY_BTN_SELECT = 2;
  localparam int JOY_BTN_START  = 3;
  localparam int JOY_BTN_UP     = 4;
  localparam int JOY_BTN_DOWN   = 5;
  localparam int JOY_BTN_LEFT   = 6;
  localparam int JOY_BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_LATCH,
    CAP_GAP,
    CAP_CLKH,
    CAP_CLKL,
    CAP_DONE
  } cap_state_e;

endpackage

// File: rtl/joypad_serial_capture.sv
// Autonomous poller for two 4021-style serial controllers.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   pad1_data, pad2_data serial data from the pads, active-low
//   snap1, snap2         last complete button bytes, active-high, bit 0 = A
//   pad_latch, pad_clk   parallel-load pulse and shift clock to both pads
//
// state      | meaning
// CAP_IDLE   | waiting for a poll tick (or a pending one)
// CAP_LATCH  | pad_latch high for CLK_DIV cycles
// CAP_GAP    | pad_latch low for CLK_DIV cycles, bit 0 sampled on last cycle
// CAP_CLKH   | pad_clk high for CLK_DIV cycles
// CAP_CLKL   | pad_clk low for CLK_DIV cycles, bit 1..7 sampled on last cycle
// CAP_DONE   | one cycle, both captured bytes committed to snap together
module joypad_serial_capture
  import mem_pkg::*;
#(
  parameter int CLK_DIV     = 6,
  parameter int POLL_PERIOD = 357955
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad1_data,
  input  logic       pad2_data,
  output logic [7:0] snap1,
  output logic [7:0] snap2,
  output logic       pad_latch,
  output logic       pad_clk
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);

  cap_state_e    state_q;
  logic [PW-1:0] poll_q;
  logic [7:0]    div_q;
  logic [2:0]    bit_q;
  logic [7:0]    tmp1_q, tmp2_q;
  logic [7:0]    snap1_q, snap2_q;
  logic          pend_q;
  logic          pad_latch_q, pad_clk_q;
  logic          tick;
  logic          div_done;

  // Reset value of POLL_LAST makes the first tick land in the first cycle
  // after reset is released.
  assign tick     = (poll_q == POLL_LAST);
  assign div_done = (div_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_q <= POLL_LAST;
    end else begin
      poll_q <= tick ? '0 : poll_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CAP_IDLE;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      tmp1_q      <= 8'h00;
      tmp2_q      <= 8'h00;
      snap1_q     <= 8'h00;
      snap2_q     <= 8'h00;
      pend_q      <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
    end else begin
      // A tick during a capture is remembered once; further ticks merge.
      if (tick && (state_q != CAP_IDLE)) pend_q <= 1'b1;

      case (state_q)
        CAP_IDLE: begin
          if (tick || pend_q) begin
            state_q     <= CAP_LATCH;
            pad_latch_q <= 1'b1;
            div_q       <= DIV_LAST;
            pend_q      <= 1'b0;
          end
        end
        CAP_LATCH: begin
          if (div_done) begin
            state_q     <= CAP_GAP;
            pad_latch_q <= 1'b0;
            div_q       <= DIV_LAST;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        CAP_GAP: begin
          if (div_done) begin
            // Shift in from the top so the first sample ends up in bit 0.
            tmp1_q    <= {~pad1_data, tmp1_q[7:1]};
            tmp2_q    <= {~pad2_data, tmp2_q[7:1]};
            bit_q     <= 3'd1;
            state_q   <= CAP_CLKH;
            pad_clk_q <= 1'b1;
            div_q     <= DIV_LAST;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        CAP_CLKH: begin
          if (div_done) begin
            state_q   <= CAP_CLKL;
            pad_clk_q <= 1'b0;
            div_q     <= DIV_LAST;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        CAP_CLKL: begin
          if (div_done) begin
            tmp1_q <= {~pad1_data, tmp1_q[7:1]};
            tmp2_q <= {~pad2_data, tmp2_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= CAP_DONE;
            end else begin
              bit_q     <= bit_q + 3'd1;
              state_q   <= CAP_CLKH;
              pad_clk_q <= 1'b1;
              div_q     <= DIV_LAST;
            end
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        CAP_DONE: begin
          snap1_q <= tmp1_q;
          snap2_q <= tmp2_q;
          state_q <= CAP_IDLE;
        end
        default: begin
          state_q     <= CAP_IDLE;
          pad_latch_q <= 1'b0;
          pad_clk_q   <= 1'b0;
        end
      endcase
    end
  end

  assign snap1     = snap1_q;
  assign snap2     = snap2_q;
  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;

endmodule

// File: rtl/joypad_io.sv
// CPU-bus responder for the joypad ports $4016/$4017.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   cpu_addr/wdata/we/re     CPU bus request (one-cycle strobes)
//   cpu_rdata, cpu_rvalid    registered read response, one cycle after re
//   pad_latch, pad_clk       controller latch/clock, driven by the poller
//   pad1_data, pad2_data     controller serial data, active-low
// Owns the strobe bit and the two read shift registers; the poller keeps
// snap1/snap2 up to date independently of CPU activity.
module joypad_io
  import mem_pkg::*;
#(
  parameter int CLK_DIV     = 6,
  parameter int POLL_PERIOD = 357955
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad1_data,
  input  logic        pad2_data
);

  logic [7:0] snap1, snap2;
  logic [7:0] sr1_q, sr2_q;
  logic [7:0] rdata_q;
  logic       rvalid_q;
  logic       strobe_q;
  logic       wr_hit, rd_hit1, rd_hit2, rd_bit;
  logic       unused_wdata;

  joypad_serial_capture #(
    .CLK_DIV     (CLK_DIV),
    .POLL_PERIOD (POLL_PERIOD)
  ) u_capture (
    .clk       (clk),
    .rst       (rst),
    .pad1_data (pad1_data),
    .pad2_data (pad2_data),
    .snap1     (snap1),
    .snap2     (snap2),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk)
  );

  // A cycle with both we and re is treated as a write only.
  assign wr_hit  = cpu_we && (cpu_addr == ADDR_JOYPAD1);
  assign rd_hit1 = cpu_re && !cpu_we && (cpu_addr == ADDR_JOYPAD1);
  assign rd_hit2 = cpu_re && !cpu_we && (cpu_addr == ADDR_JOYPAD2);
  assign rd_bit  = rd_hit1 ? sr1_q[0] : sr2_q[0];

  assign unused_wdata = ^cpu_wdata[7:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q <= 1'b0;
      sr1_q    <= 8'h00;
      sr2_q    <= 8'h00;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_hit) strobe_q <= cpu_wdata[0];

      rvalid_q <= rd_hit1 || rd_hit2;
      rdata_q  <= (rd_hit1 || rd_hit2) ? {JOY_OPEN_BUS[7:1], rd_bit} : 8'h00;

      // While strobe is high the registers track snap continuously;
      // once it drops, each read shifts out one bit and fills with 1.
      if (strobe_q) begin
        sr1_q <= snap1;
        sr2_q <= snap2;
      end else begin
        if (rd_hit1) sr1_q <= {1'b1, sr1_q[7:1]};
        if (rd_hit2) sr2_q <= {1'b1, sr2_q[7:1]};
      end
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;

endmodule

// File: tb/tb_joypad_io.sv
module tb_joypad_io;

  localparam int D       = 2;
  localparam int P       = 50;
  localparam int DONE_PH = 16 * D;
  localparam logic [15:0] A1 = 16'h4016;
  localparam logic [15:0] A2 = 16'h4017;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad1_data = 1'b1;
  logic        pad2_data = 1'b1;

  always #5 clk = ~clk;

  joypad_io #(.CLK_DIV(D), .POLL_PERIOD(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .pad1_data  (pad1_data),
    .pad2_data  (pad2_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Two serial controllers: load buttons while latch is high, shift on pad_clk rise.
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic [7:0] ctl1 = 8'h00, ctl2 = 8'h00;
  logic       pclk_prev = 1'b0;
  always @(negedge clk) begin
    if (pad_latch === 1'b1) begin
      ctl1 = btn1;
      ctl2 = btn2;
    end else if (pad_clk === 1'b1 && !pclk_prev) begin
      ctl1 = {1'b0, ctl1[7:1]};
      ctl2 = {1'b0, ctl2[7:1]};
    end
    pclk_prev = (pad_clk === 1'b1);
    pad1_data = ~ctl1[0];
    pad2_data = ~ctl2[0];
  end

  // Reference model: cycle index since reset, poll schedule by arithmetic,
  // each pad's read port as (frozen byte, number of reads taken).
  int         cur = 0;
  logic [7:0] snap1_m = 8'h00, snap2_m = 8'h00, cap1_m = 8'h00, cap2_m = 8'h00;
  logic [7:0] byte1_m = 8'h00, byte2_m = 8'h00;
  int         idx1 = 0, idx2 = 0;
  logic       strobe_m = 1'b0;
  logic [7:0] exp_rdata = 8'h00;
  logic       exp_rvalid = 1'b0;

  function automatic int phase_of(input int c);
    if (c < 1) return -1;
    return (c - 1) % P;
  endfunction

  function automatic logic exp_latch(input int c);
    int o = phase_of(c);
    return (o >= 0) && (o < D);
  endfunction

  function automatic logic exp_pclk(input int c);
    int o = phase_of(c);
    if (o < 2 * D || o >= 16 * D) return 1'b0;
    return (((o - 2 * D) / D) % 2) == 0;
  endfunction

  function automatic logic pick(input logic [7:0] b, input int i);
    if (i >= 8) return 1'b1;
    return b[i];
  endfunction

  always @(posedge clk) begin
    logic rd1, rd2;
    int   o;
    if (rst) begin
      cur = 0;
      snap1_m = 8'h00; snap2_m = 8'h00;
      byte1_m = 8'h00; byte2_m = 8'h00;
      idx1 = 0; idx2 = 0;
      strobe_m = 1'b0;
      exp_rdata = 8'h00; exp_rvalid = 1'b0;
    end else begin
      o   = phase_of(cur);
      rd1 = cpu_re && !cpu_we && (cpu_addr == A1);
      rd2 = cpu_re && !cpu_we && (cpu_addr == A2);
      if (rd1) begin
        exp_rdata = 8'h40 | {7'b0, pick(byte1_m, idx1)}; exp_rvalid = 1'b1;
      end else if (rd2) begin
        exp_rdata = 8'h40 | {7'b0, pick(byte2_m, idx2)}; exp_rvalid = 1'b1;
      end else begin
        exp_rdata = 8'h00; exp_rvalid = 1'b0;
      end
      if (strobe_m) begin
        byte1_m = snap1_m; byte2_m = snap2_m; idx1 = 0; idx2 = 0;
      end else begin
        if (rd1 && idx1 < 8) idx1++;
        if (rd2 && idx2 < 8) idx2++;
      end
      if (cpu_we && cpu_addr == A1) strobe_m = cpu_wdata[0];
      if (o == 0) begin cap1_m = btn1; cap2_m = btn2; end
      if (o == DONE_PH) begin snap1_m = cap1_m; snap2_m = cap2_m; end
      cur++;
    end
  end

  logic       chk_en = 1'b0;
  logic       rec_lat = 1'b0;
  logic [7:0] rq[$];
  logic [7:0] eq[$];
  logic       lat_hist [0:7];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata", cpu_rdata, exp_rdata);
      chk("rvalid", {7'b0, cpu_rvalid}, {7'b0, exp_rvalid});
      chk("pad_latch", {7'b0, pad_latch}, {7'b0, exp_latch(cur)});
      chk("pad_clk", {7'b0, pad_clk}, {7'b0, exp_pclk(cur)});
    end
    if (cpu_rvalid === 1'b1) rq.push_back(cpu_rdata);
    if (rec_lat && cur < 8) lat_hist[cur] = pad_latch;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    cpu_addr = a; cpu_re = 1'b1;
    @(negedge clk);
    cpu_re = 1'b0;
  endtask

  task automatic wait_phase(input string nm, input int lo, input int hi);
    int k = 0;
    while (!(phase_of(cur) >= lo && phase_of(cur) <= hi)) begin
      if (k == 3 * P) begin
        n_cmp++; n_err++;
        $display("FAIL %s: phase window %0d..%0d not reached, at phase %0d", nm, lo, hi, phase_of(cur));
        return;
      end
      k++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string nm);
    wait_phase(nm, DONE_PH + 1, P - 3);
  endtask

  task automatic wait_commit(input string nm);
    if (phase_of(cur) == DONE_PH + 1) idle(1);
    wait_phase(nm, DONE_PH + 1, DONE_PH + 1);
    idle(2);
  endtask

  task automatic check_reads(input string nm);
    idle(2);
    n_cmp++;
    if (rq.size() != eq.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d reads, expected %0d", nm, rq.size(), eq.size());
    end
    for (int i = 0; i < eq.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), (i < rq.size()) ? rq[i] : 8'hxx, eq[i]);
    rq.delete();
  endtask

  initial begin
    logic [5:0] lat_exp;
    btn1 = 8'h09;
    btn2 = 8'h00;
    repeat (3) @(negedge clk);
    chk_en  = 1'b1;
    rec_lat = 1'b1;
    rst     = 1'b0;
    idle(12);
    rec_lat = 1'b0;
    lat_exp = 6'b000110;
    for (int i = 0; i < 6; i++)
      chk($sformatf("first_latch[%0d]", i), {7'b0, lat_hist[i]}, {7'b0, lat_exp[i]});

    // A and Start pressed on pad 1
    wait_commit("first_capture");
    rq.delete();
    wr(A1, 8'h01);
    wr(A1, 8'h00);
    repeat (10) rd(A1);
    eq = {8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    check_reads("full_seq");

    // Right only on pad 2
    wait_idle("pad2_setup");
    btn1 = 8'h00; btn2 = 8'h80;
    wait_commit("pad2_capture");
    rq.delete();
    wr(A1, 8'h01);
    wr(A1, 8'h00);
    repeat (8) rd(A2);
    rd(A1);
    eq = {8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h40};
    check_reads("pad2_seq");

    // Strobe held high
    wait_idle("strobe_setup");
    btn1 = 8'h01; btn2 = 8'h00;
    wait_commit("strobe_capture");
    rq.delete();
    wr(A1, 8'h01);
    idle(1);
    repeat (5) rd(A1);
    wait_idle("strobe_release");
    btn1 = 8'h00;
    wait_commit("strobe_capture2");
    rd(A1);
    eq = {8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h40};
    check_reads("strobe_held");

    // New snapshot committed between reads 3 and 4
    wait_idle("midread_setup");
    btn1 = 8'hA5;
    wait_commit("midread_capture");
    rq.delete();
    wr(A1, 8'h00);
    repeat (3) rd(A1);
    wait_idle("midread_change");
    btn1 = 8'h3C;
    wait_commit("midread_capture2");
    repeat (6) rd(A1);
    eq = {8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41, 8'h41};
    check_reads("mid_read");

    // Reset during CLKH of bit 4
    wait_phase("rst_mid", 8 * D, 8 * D);
    chk("pclk_before_rst", {7'b0, pad_clk}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    chk("pclk_after_rst", {7'b0, pad_clk}, 8'h00);
    chk("latch_after_rst", {7'b0, pad_latch}, 8'h00);
    rst = 1'b0;
    rq.delete();
    wr(A1, 8'h01);
    wr(A1, 8'h00);
    rd(A1);
    eq = {8'h40};
    check_reads("rst_mid_read");

    // Randomized bus traffic and button changes
    for (int i = 0; i < 900; i++) begin
      int r;
      int o;
      r = $urandom_range(0, 99);
      o = phase_of(cur);
      if (o >= DONE_PH + 1 && o <= P - 3 && $urandom_range(0, 15) == 0) begin
        btn1 = 8'($urandom);
        btn2 = 8'($urandom);
      end
      if (r < 35) begin
        idle(1);
      end else if (r < 60) begin
        rd(A1);
      end else if (r < 80) begin
        rd(A2);
      end else if (r < 85) begin
        rd(16'h4000 + 16'($urandom_range(0, 31)));
      end else if (r < 93) begin
        wr(A1, 8'($urandom));
      end else if (r < 96) begin
        wr(($urandom_range(0, 1) == 0) ? A2 : 16'h2000, 8'($urandom));
      end else begin
        cpu_addr  = ($urandom_range(0, 1) == 0) ? A1 : A2;
        cpu_wdata = 8'($urandom);
        cpu_we    = 1'b1;
        cpu_re    = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_re = 1'b0;
      end
    end

    idle(4);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
